// File: rtl/simon_game_fsm.sv
// Simon memory game controller: button sync/debounce, LFSR-generated colour sequence, playback and check.
// Define SIMON_TIMEOUT_EN to end the game when the player stays idle in WAIT_IN for TIMEOUT_CYCLES.
module simon_game_fsm #(
  parameter int MAX_LEN         = 32,
  parameter int ON_CYCLES       = 25000000,
  parameter int OFF_CYCLES      = 12500000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 150000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       simonTurn,
  output logic       gameOver,
  output logic [5:0] level
);

  typedef enum logic [2:0] {
    IDLE, GAP, SHOW_ON, SHOW_OFF, WAIT_IN, WAIT_REL, OVER
  } state_t;

  localparam int PHASE_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);

  // x^16+x^14+x^13+x^11, right-shifting Fibonacci form
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t          state, state_n;
  logic [5:0]      lvl, lvl_n, idx, idx_n;
  logic [15:0]     free, seed, seed_n, rep, rep_n;
  logic [PW-1:0]   ph, ph_n;
  logic [3:0]      btn_s1, btn_s2, cand, db, db_q;
  logic [DW-1:0]   dcnt;
  logic [3:0]      led_c, exp_oh;
  logic [5:0]      level_c;
  logic            turn_c, over_c, press;

  // Input sync, debounce and free-running LFSR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      cand   <= '0;
      dcnt   <= '0;
      db     <= '0;
      db_q   <= '0;
      free   <= 16'hACE1;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      db_q   <= db;
      free   <= lfsr_step(free);
      if (btn_s2 != cand) begin
        cand <= btn_s2;
        dcnt <= DW'(1);
      end else if (dcnt != DW'(DEBOUNCE_CYCLES)) begin
        dcnt <= dcnt + DW'(1);
      end else begin
        db <= cand;
      end
    end
  end

  assign press  = (db_q == 4'b0000) && (db != 4'b0000);
  assign exp_oh = 4'b0001 << rep[1:0];

`ifdef SIMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt, to_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt <= '0;
    else     to_cnt <= to_n;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lvl   <= '0;
      idx   <= '0;
      seed  <= 16'hACE1;
      rep   <= 16'hACE1;
      ph    <= '0;
    end else begin
      state <= state_n;
      lvl   <= lvl_n;
      idx   <= idx_n;
      seed  <= seed_n;
      rep   <= rep_n;
      ph    <= ph_n;
    end
  end

  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    idx_n   = idx;
    seed_n  = seed;
    rep_n   = rep;
    ph_n    = ph;
    led_c   = '0;
    turn_c  = 1'b1;
    over_c  = 1'b0;
    level_c = lvl;
`ifdef SIMON_TIMEOUT_EN
    to_n    = '0;
`endif
    case (state)
      IDLE: begin
        level_c = '0;
        if (start) begin
          seed_n  = free;
          lvl_n   = 6'd1;
          idx_n   = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        ph_n = ph + PW'(1);
        if (ph == PW'(OFF_CYCLES - 1)) begin
          rep_n   = seed;
          idx_n   = '0;
          state_n = SHOW_ON;
        end
      end
      SHOW_ON: begin
        led_c = exp_oh;
        ph_n  = ph + PW'(1);
        if (ph == PW'(ON_CYCLES - 1)) state_n = SHOW_OFF;
      end
      SHOW_OFF: begin
        ph_n = ph + PW'(1);
        if (ph == PW'(OFF_CYCLES - 1)) begin
          if (idx + 6'd1 == lvl) begin
            rep_n   = seed;
            idx_n   = '0;
            state_n = WAIT_IN;
          end else begin
            rep_n   = lfsr_step(rep);
            idx_n   = idx + 6'd1;
            state_n = SHOW_ON;
          end
        end
      end
      WAIT_IN: begin
        turn_c = 1'b0;
        led_c  = db;
        // A matching one-hot vector is the only accepted press; multi-bit never equals exp_oh
        if (press) state_n = (db == exp_oh) ? WAIT_REL : OVER;
`ifdef SIMON_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) state_n = OVER;
        else to_n = to_cnt + TW'(1);
`endif
      end
      WAIT_REL: begin
        turn_c = 1'b0;
        led_c  = db;
        if (db == 4'b0000) begin
          if (idx + 6'd1 == lvl) begin
            idx_n = '0;
            if (lvl == 6'(MAX_LEN)) begin
              state_n = OVER;
            end else begin
              lvl_n   = lvl + 6'd1;
              state_n = GAP;
            end
          end else begin
            idx_n   = idx + 6'd1;
            rep_n   = lfsr_step(rep);
            state_n = WAIT_IN;
          end
        end
      end
      OVER: begin
        turn_c = 1'b0;
        over_c = 1'b1;
        if (start) begin
          seed_n  = free;
          lvl_n   = 6'd1;
          idx_n   = '0;
          state_n = GAP;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) ph_n = '0;
  end

  // Outputs follow the current state one clock later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led       <= '0;
      simonTurn <= 1'b1;
      gameOver  <= 1'b0;
      level     <= '0;
    end else begin
      led       <= led_c;
      simonTurn <= turn_c;
      gameOver  <= over_c;
      level     <= level_c;
    end
  end

endmodule

// File: tb/tb_simon_game_fsm.sv
// Scoreboard bench for simon_game_fsm: expectations are queued as stimulus is driven, then popped against outputs.
module tb_simon_game_fsm;
  localparam int ON = 4, OFF = 2, DEB = 3, TO = 50, MAXL = 3;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] led;
  logic       simonTurn, gameOver;
  logic [5:0] level;

  simon_game_fsm #(
    .MAX_LEN(MAXL), .ON_CYCLES(ON), .OFF_CYCLES(OFF),
    .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn),
    .led(led), .simonTurn(simonTurn), .gameOver(gameOver), .level(level)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  string       tq[$];
  logic [31:0] vq[$];
  logic [15:0] m_free, seed_m;

  // Reference LFSR: feedback is the parity of taps 0,2,3,5 shifted into bit 15
  function automatic logic [15:0] m_next(input logic [15:0] x);
    return {^(x & 16'h002D), x[15:1]};
  endfunction

  function automatic logic [3:0] colour(input logic [15:0] s, input int k);
    logic [15:0] x;
    x = s;
    for (int i = 0; i < k; i++) x = m_next(x);
    return 4'b0001 << x[1:0];
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_free <= 16'hACE1;
    else     m_free <= m_next(m_free);
  end

  task automatic expect_v(input string t, input logic [31:0] v);
    tq.push_back(t);
    vq.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string t;
    logic [31:0] v;
    tests++;
    if (tq.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0d", obs);
    end else begin
      t = tq.pop_front();
      v = vq.pop_front();
      assert (obs === v) else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", t, obs, v);
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start  = 1'b1;
    seed_m = m_free;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_running();
    int w;
    w = 0;
    while (gameOver !== 1'b0 && w < 60) begin @(negedge clk); w++; end
    expect_v("restart_gameover", 0);
    check(gameOver);
  endtask

  task automatic expect_playback(input int L);
    expect_v("pb_level", L);
    expect_v("pb_lead_dark", OFF);
    for (int k = 0; k < L; k++) begin
      expect_v("pb_colour", colour(seed_m, k));
      expect_v("pb_on_len", ON);
      expect_v("pb_off_len", OFF);
    end
    expect_v("pb_turn_end", 0);
  endtask

  task automatic observe_playback(input int L);
    int w;
    logic [3:0] c;
    w = 0;
    while (level !== 6'(L) && w < 60) begin @(negedge clk); w++; end
    check(level);
    w = 0;
    while (simonTurn === 1'b1 && gameOver === 1'b0 && led === 4'b0 && w < 60) begin
      w++; @(negedge clk);
    end
    check(w);
    for (int k = 0; k < L; k++) begin
      c = led;
      check(c);
      w = 0;
      while (led === c && c != 4'b0 && w < 60) begin w++; @(negedge clk); end
      check(w);
      w = 0;
      while (led === 4'b0 && simonTurn === 1'b1 && w < 60) begin w++; @(negedge clk); end
      check(w);
    end
    check(simonTurn);
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    btn = v;
    repeat (5) @(negedge clk);
    btn = 4'b0000;
  endtask

  task automatic wait_over();
    int w;
    w = 0;
    while (gameOver !== 1'b1 && w < 80) begin @(negedge clk); w++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    expect_v("rst_led", 0);  check(led);
    expect_v("rst_turn", 1); check(simonTurn);
    expect_v("rst_over", 0); check(gameOver);
    expect_v("rst_level", 0); check(level);
    rst = 1'b0;

    // Level 1 playback
    do_start();
    expect_playback(1);
    observe_playback(1);

    // Two-clock glitch of a wrong colour must not register
    expect_v("glitch_over", 0);
    expect_v("glitch_turn", 0);
    expect_v("glitch_led", 0);
    @(negedge clk);
    btn = rot(colour(seed_m, 0));
    repeat (2) @(negedge clk);
    btn = 4'b0000;
    repeat (12) @(negedge clk);
    check(gameOver); check(simonTurn); check(led);

    // Round 1 correct -> level 2 playback
    press(colour(seed_m, 0));
    expect_playback(2);
    observe_playback(2);

    // Round 2 correct -> level 3 playback
    press(colour(seed_m, 0));
    repeat (10) @(negedge clk);
    press(colour(seed_m, 1));
    expect_playback(3);
    observe_playback(3);

    // Round 3 correct at MAX_LEN -> win
    press(colour(seed_m, 0));
    repeat (10) @(negedge clk);
    press(colour(seed_m, 1));
    repeat (10) @(negedge clk);
    press(colour(seed_m, 2));
    expect_v("win_over", 1);
    expect_v("win_level", 3);
    expect_v("win_led", 0);
    expect_v("win_turn", 0);
    wait_over();
    check(gameOver); check(level); check(led); check(simonTurn);

    // Restart from OVER, then a wrong colour
    do_start();
    wait_running();
    expect_playback(1);
    observe_playback(1);
    press(rot(colour(seed_m, 0)));
    expect_v("wrong_over", 1);
    expect_v("wrong_level", 1);
    expect_v("wrong_led", 0);
    wait_over();
    check(gameOver); check(level); check(led);

    // Restart, then two buttons at once
    do_start();
    wait_running();
    expect_playback(1);
    observe_playback(1);
    press(4'b0011);
    expect_v("multi_over", 1);
    expect_v("multi_level", 1);
    wait_over();
    check(gameOver); check(level);

    // Restart; start during WAIT_IN is ignored; idle behaviour
    do_start();
    wait_running();
    expect_playback(1);
    observe_playback(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    expect_v("start_ignored_turn", 0);
    expect_v("start_ignored_level", 1);
    check(simonTurn); check(level);
`ifdef SIMON_TIMEOUT_EN
    expect_v("timeout_over", 1);
    wait_over();
    check(gameOver);
`else
    expect_v("no_timeout_over", 0);
    expect_v("no_timeout_turn", 0);
    repeat (1000) @(negedge clk);
    check(gameOver); check(simonTurn);
`endif

    // Reset mid-playback abandons the game
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    do_start();
    repeat (4) @(negedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    expect_v("midrst_led", 0);   check(led);
    expect_v("midrst_turn", 1);  check(simonTurn);
    expect_v("midrst_over", 0);  check(gameOver);
    expect_v("midrst_level", 0); check(level);
    @(negedge clk); rst = 1'b0;
    do_start();
    expect_playback(1);
    observe_playback(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simon_game_fsm.md
SIMON_GAME_FSM -- requirements
Module: simon_game_fsm

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- MAX_LEN, 32: longest sequence; a win ends the game.
- ON_CYCLES, 25000000: clocks each colour is lit during playback.
- OFF_CYCLES, 12500000: dark gap after each colour and before each playback.
- DEBOUNCE_CYCLES, 500000: clocks a button vector must be stable to be accepted.
- TIMEOUT_CYCLES, 150000000: player idle limit (see REQ-024).

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1: sole clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: synchronous start/restart request, level-sampled.
- btn, in, 4: raw colour buttons, active-high, asynchronous to clk.
- led, out, 4: colour lamps, one-hot or zero.
- simonTurn, out, 1: high while the machine owns the turn; feeds the 7-segment display.
- gameOver, out, 1: high from game end until next start; feeds the 7-segment display.
- level, out, 6: current sequence length, 0 in IDLE.

Function
REQ-003 SHALL double-register btn, then debounce it: the debounced vector db updates only after the synchronised vector has held one value for DEBOUNCE_CYCLES consecutive clocks.
REQ-004 SHALL generate a one-cycle press event when db goes from 4'b0000 to nonzero; a nonzero-to-nonzero change SHALL generate no event.
REQ-005 SHALL run a free-running 16-bit maximal LFSR (x^16+x^14+x^13+x^11) that is never all-zero.
REQ-006 On game start, SHALL capture seed := free LFSR value; sequence element k SHALL be bits [1:0] of a replay LFSR after k advances from seed; each playback and each check SHALL reload seed (no sequence RAM).
REQ-007 States: IDLE, GAP, SHOW_ON, SHOW_OFF, WAIT_IN, WAIT_REL, OVER.
REQ-008 IDLE: simonTurn=1, gameOver=0, led=0, level=0; start=1 -> capture seed, level:=1, enter GAP.
REQ-009 GAP: led=0, simonTurn=1; after OFF_CYCLES clocks, reload replay LFSR and enter SHOW_ON with index 0.
REQ-010 SHOW_ON: led=one-hot(element); after ON_CYCLES -> SHOW_OFF.
REQ-011 SHOW_OFF: led=0; after OFF_CYCLES, index+1; if index==level -> reload replay LFSR, index:=0, WAIT_IN; else SHOW_ON.
REQ-012 WAIT_IN: simonTurn=0, led=db; presses are ignored in all states except WAIT_IN.
REQ-013 Press in WAIT_IN: if db is one-hot and equals the expected element -> WAIT_REL; otherwise (wrong colour or more than one bit set) -> OVER.
REQ-014 WAIT_REL: led=db; on db==0, index+1; if index==level: level==MAX_LEN -> OVER (win), else level+1 and GAP; otherwise WAIT_IN.
REQ-015 OVER: gameOver=1, simonTurn=0, led=0, level held; start=1 -> IDLE processing as in REQ-008 on the same clock (new seed, level=1, GAP).
REQ-016 start SHALL be ignored in every state except IDLE and OVER.
REQ-017 All outputs SHALL be registered; state-to-output latency is exactly one clock.
REQ-018 Phase counters SHALL clear on every state change; a count of N SHALL hold the phase exactly N clocks.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, led=0, simonTurn=1, gameOver=0, level=0, index=0, db=0, and all phase, debounce and timeout counters to 0.
REQ-020 Free LFSR SHALL reset to 16'hACE1.
REQ-021 rst asserted mid-playback or mid-input SHALL abandon the game with no residual press event after release.

Configuration
REQ-022 Macro SIMON_TIMEOUT_EN selects the player timeout.
REQ-023 Without SIMON_TIMEOUT_EN: WAIT_IN waits indefinitely; no timeout counter is synthesised.
REQ-024 With SIMON_TIMEOUT_EN: a counter clears on entry to WAIT_IN and increments each WAIT_IN clock; reaching TIMEOUT_CYCLES -> OVER; WAIT_REL does not time out.

Verification (params: ON=4, OFF=2, DEBOUNCE=3, TIMEOUT=50, MAX_LEN=3)
REQ-025 Reset then start pulse -> level=1, led dark 2 clk, one-hot led 4 clk, dark 2 clk, then simonTurn=0.
REQ-026 Correct colour held 5 clk, then released -> level=2 and a two-colour playback; the first colour matches the level-1 colour.
REQ-027 Wrong colour, or btn=4'b0011, in WAIT_IN -> gameOver=1, level held, led=0; start -> gameOver=0, level=1.
REQ-028 Button glitch of 2 clk -> no press event and no state change.
REQ-029 Three correct rounds -> gameOver=1 with level=3.
REQ-030 SIMON_TIMEOUT_EN defined, no press for 50 clk in WAIT_IN -> OVER; undefined -> still WAIT_IN after 1000 clk.
